ifm_rd_port: RTL and testbench
==============================

Name: ifm_rd_port

Overview:
- Single-port read/write front end for the input-feature-map (IFM) SRAM macro.
- Downstream of the conv read DMA: consumes its address stream (addr/first/last, valid/ready) and issues synchronous SRAM reads.
- Returns read data, with first/last aligned, to the DMA data input through a credit-protected output FIFO.
- Also accepts fill writes from the IFM load path; writes have priority over reads.

Parameters:
- DW, 64, data width of SRAM word and of data stream
- AW, 14, address width
- DEPTH, 16384, number of valid SRAM words; addresses >= DEPTH are out of range
- FD, 4, output FIFO depth (entries); must be >= 3 for one-read-per-cycle throughput

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_addr  in  AW  read address from DMA
- m_addr_first  in  1  first address of a transfer
- m_addr_last  in  1  last address of a transfer
- m_addr_valid  in  1  read address valid
- m_addr_ready  out  1  read address accepted
- wr_addr  in  AW  fill write address
- wr_data  in  DW  fill write data
- wr_valid  in  1  fill write request
- wr_ready  out  1  fill write accepted
- mem_en  out  1  SRAM access enable (combinational)
- mem_we  out  1  SRAM write enable (combinational)
- mem_addr  out  AW  SRAM address (combinational)
- mem_wdata  out  DW  SRAM write data (combinational)
- mem_rdata  in  DW  SRAM read data, valid one cycle after a read
- s_data  out  DW  read data to DMA
- s_first  out  1  first flag aligned with s_data
- s_last  out  1  last flag aligned with s_data
- s_valid  out  1  data valid
- s_ready  in  1  data accepted
- oor_err  out  1  sticky out-of-range read flag
- clr_err  in  1  synchronous clear of oor_err

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, credit count cnt=0, in-flight stage invalid, oor_err=0.
  - s_valid=0, s_data/s_first/s_last=0.
  - m_addr_ready=0 and wr_ready=0 while rst_n=0, so mem_en=0.
  - A reset mid-transfer discards all in-flight and buffered data; the DMA must restart its transfer.
- Write path:
  - wr_ready=1 whenever out of reset.
  - wr_valid&wr_ready drives mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - Writes to addresses >= DEPTH are dropped: mem_en=0, no error.
- Read accept:
  - m_addr_ready = !wr_valid && (cnt < FD). This is a registered-state function with no combinational path from s_ready.
  - Accept (m_addr_valid&m_addr_ready) drives mem_en=1, mem_we=0, mem_addr=m_addr.
  - Out-of-range accept: mem_en=0, the entry still flows with data forced to 0, and oor_err is set the next cycle.
- In-flight stage:
  - On accept, register {first,last,oor} with a valid bit.
  - Next cycle, push {oor?0:mem_rdata, first, last} into the FIFO.
  - The push always succeeds because the credit guarantees space.
- Credit counter:
  - cnt counts in-flight plus FIFO entries.
  - cnt_next = cnt + accept - pop, where pop = s_valid&s_ready.
  - Simultaneous accept and pop leaves cnt unchanged.
  - cnt never exceeds FD and never underflows.
- Output:
  - s_valid = FIFO not empty; the head drives s_data/s_first/s_last from registers.
  - Data stays stable while s_valid&!s_ready.
- Latency and throughput:
  - Accept at cycle N: SRAM read at edge N+1, FIFO push at end of N+1, s_valid at N+2. Fixed 2-cycle latency from an empty pipe.
  - With s_ready=1 and FD>=3, one read per cycle is sustained.
  - With s_ready=0, exactly FD reads are accepted, then m_addr_ready drops.
- FIFO pointers: FIFO is a circular buffer with wrap-around pointers; full and empty are distinguished by the occupancy count.
- Error flag:
  - oor_err is set by any out-of-range read and holds until clr_err.
  - If clr_err and a new set occur in the same cycle, the set wins.
- Ordering: data order equals address accept order; first/last flags pass through unmodified.

Test Plan:
- Write words 0x0..0x9 with data=addr*0x1111, then read addresses 0..9 with first on 0 and last on 9, s_ready=1 -> s_data 0x0000,0x1111,...,0x9999 in order, first/last on beats 1 and 10, first s_valid 2 cycles after first accept, 10 consecutive beats.
- Hold s_ready=0 and issue 8 reads -> exactly FD=4 accepted and m_addr_ready=0 afterwards; release s_ready -> all 8 delivered in order with no drop or duplicate.
- Assert wr_valid during a read burst -> m_addr_ready=0 for those cycles, mem_we=1 with wr_addr; read data stays correct; reading the written address afterwards returns the new data.
- Read address 16384 with DEPTH=16384 -> mem_en=0, s_data=0 with flags preserved, oor_err=1 next cycle; clr_err pulse -> oor_err=0; clr_err coincident with a new OOR read -> oor_err stays 1.
- Pulse rst_n low mid-burst with 3 entries buffered -> s_valid=0, m_addr_ready=0 immediately; after release cnt=0, and a fresh 2-address transfer returns correct data.
- Random s_ready toggling over 1000 reads against a scoreboard -> order, data and flags match; cnt never exceeds FD.

Source files
------------

// File: rtl/ifm_rd_port.sv
// IFM SRAM front end: arbitrates fill writes over DMA reads, and returns read
// data in order through a credit-protected output FIFO.
module ifm_rd_port #(
  parameter int unsigned DW    = 64,
  parameter int unsigned AW    = 14,
  parameter int unsigned DEPTH = 16384,
  parameter int unsigned FD    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] m_addr,
  input  logic          m_addr_first,
  input  logic          m_addr_last,
  input  logic          m_addr_valid,
  output logic          m_addr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] s_data,
  output logic          s_first,
  output logic          s_last,
  output logic          s_valid,
  input  logic          s_ready,
  output logic          oor_err,
  input  logic          clr_err
);

  localparam int unsigned PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int unsigned CW = $clog2(FD + 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          first;
    logic          last;
  } beat_t;

  logic          w_wr_fire;
  logic          w_wr_inrange;
  logic          w_rd_fire;
  logic          w_rd_oor;
  logic          w_pop;
  beat_t         w_push_beat;

  logic [CW-1:0] r_cnt;
  logic          r_if_vld;
  logic          r_if_first;
  logic          r_if_last;
  logic          r_if_oor;
  logic          r_oor_err;

  beat_t         r_fifo [FD];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_fcnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshakes: writes always win the single SRAM port; reads need a credit.
  assign wr_ready     = rst_n;
  assign m_addr_ready = rst_n & ~wr_valid & (r_cnt < CW'(FD));
  assign w_wr_fire    = wr_valid & wr_ready;
  assign w_rd_fire    = m_addr_valid & m_addr_ready;
  assign w_wr_inrange = 32'(wr_addr) < DEPTH;
  assign w_rd_oor     = 32'(m_addr) >= DEPTH;
  assign w_pop        = s_valid & s_ready;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_wr_fire) begin
      mem_en    = w_wr_inrange;
      mem_we    = w_wr_inrange;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else if (w_rd_fire) begin
      mem_en   = ~w_rd_oor;
      mem_addr = m_addr;
    end
  end

  // Credit counter covers the in-flight stage plus FIFO occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case ({w_rd_fire, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // In-flight stage tracks flags while the SRAM read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_vld   <= 1'b0;
      r_if_first <= 1'b0;
      r_if_last  <= 1'b0;
      r_if_oor   <= 1'b0;
    end else begin
      r_if_vld   <= w_rd_fire;
      r_if_first <= m_addr_first;
      r_if_last  <= m_addr_last;
      r_if_oor   <= w_rd_oor;
    end
  end

  always_comb begin
    w_push_beat       = '0;
    w_push_beat.data  = r_if_oor ? '0 : mem_rdata;
    w_push_beat.first = r_if_first;
    w_push_beat.last  = r_if_last;
  end

  // Output FIFO; the credit scheme guarantees a push never sees it full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcnt   <= '0;
      for (int i = 0; i < FD; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      if (r_if_vld) begin
        r_fifo[r_wr_ptr] <= w_push_beat;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({r_if_vld, w_pop})
        2'b10:   r_fcnt <= r_fcnt + CW'(1);
        2'b01:   r_fcnt <= r_fcnt - CW'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  assign s_valid = (r_fcnt != '0);
  assign s_data  = r_fifo[r_rd_ptr].data;
  assign s_first = r_fifo[r_rd_ptr].first;
  assign s_last  = r_fifo[r_rd_ptr].last;

  // Sticky error: a new out-of-range read beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oor_err <= 1'b0;
    end else begin
      r_oor_err <= (w_rd_fire & w_rd_oor) | (r_oor_err & ~clr_err);
    end
  end

  assign oor_err = r_oor_err;

endmodule

// File: tb/tb_ifm_rd_port.sv
// Scoreboard bench for ifm_rd_port with a behavioural SRAM model.
module tb_ifm_rd_port;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 15;
  localparam int unsigned DEPTH = 16384;
  localparam int unsigned FD    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic          m_addr_first = 1'b0;
  logic          m_addr_last = 1'b0;
  logic          m_addr_valid = 1'b0;
  logic          m_addr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] s_data;
  logic          s_first;
  logic          s_last;
  logic          s_valid;
  logic          s_ready = 1'b1;
  logic          oor_err;
  logic          clr_err = 1'b0;

  ifm_rd_port #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .FD(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_addr(m_addr), .m_addr_first(m_addr_first), .m_addr_last(m_addr_last),
    .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .s_data(s_data), .s_first(s_first), .s_last(s_last), .s_valid(s_valid),
    .s_ready(s_ready), .oor_err(oor_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          f;
    logic          l;
  } exp_t;

  bit [DW-1:0] sram    [1 << AW];
  bit [DW-1:0] ref_mem [1 << AW];
  exp_t        sbq [$];

  int total = 0, bad = 0, cyc = 0;
  int acc = 0, pops = 0, max_out = 0;
  int last_acc_cyc = 0, sv_rise_cyc = 0, first_pop_cyc = 0, last_pop_cyc = 0;
  bit pop_seen = 0, sv_prev = 0, run_tog = 0;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (acc - pops > max_out) max_out = acc - pops;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted output beat.
  always @(negedge clk) begin
    exp_t e;
    if (s_valid && !sv_prev) sv_rise_cyc = cyc;
    sv_prev = s_valid;
    if (s_valid && s_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %h with empty scoreboard", s_data);
      end else begin
        e = sbq.pop_front();
        check("rd_data",  s_data,  e.d);
        check("rd_first", 64'(s_first), 64'(e.f));
        check("rd_last",  64'(s_last),  64'(e.l));
      end
      pops++;
      if (!pop_seen) begin
        pop_seen      = 1;
        first_pop_cyc = cyc;
      end
      last_pop_cyc = cyc;
    end
  end

  task automatic rd(input logic [AW-1:0] a, input logic f, input logic l);
    int n = 0;
    exp_t e;
    m_addr = a; m_addr_first = f; m_addr_last = l; m_addr_valid = 1'b1;
    @(negedge clk);
    while (!m_addr_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!m_addr_ready) begin
      total++;
      bad++;
      $display("FAIL rd_timeout: addr %h never accepted", a);
    end else begin
      check("rd_mem_en", 64'(mem_en), (32'(a) < DEPTH) ? 64'd1 : 64'd0);
      check("rd_mem_we", 64'(mem_we), 64'd0);
      e.d = (32'(a) < DEPTH) ? ref_mem[a] : '0;
      e.f = f;
      e.l = l;
      sbq.push_back(e);
      acc++;
      last_acc_cyc = cyc;
    end
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr = a; wr_data = d; wr_valid = 1'b1;
    @(negedge clk);
    check("wr_ready", 64'(wr_ready), 64'd1);
    check("wr_blocks_rd", 64'(m_addr_ready), 64'd0);
    if (32'(a) < DEPTH) begin
      check("wr_mem_we", 64'({mem_en, mem_we}), 64'd3);
      check("wr_mem_addr", 64'(mem_addr), 64'(a));
      ref_mem[a] = d;
    end else begin
      check("wr_oor_drop", 64'(mem_en), 64'd0);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 64'(sbq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, acc_base;
    // Reset state, with requests asserted to prove the SRAM stays idle.
    m_addr_valid = 1'b1;
    wr_valid     = 1'b1;
    #2;
    check("rst_s_valid", 64'(s_valid), 64'd0);
    check("rst_s_data", s_data, 64'd0);
    check("rst_m_ready", 64'(m_addr_ready), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_oor_err", 64'(oor_err), 64'd0);
    m_addr_valid = 1'b0;
    wr_valid     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill 0..9 with addr*0x1111, drop an out-of-range write, then burst-read.
    for (int i = 0; i < 10; i++) wr(AW'(i), 64'(i) * 64'h1111);
    wr(AW'(16400), 64'hDEAD);
    pop_seen = 0;
    rd(AW'(0), 1'b1, 1'b0);
    t0 = last_acc_cyc;
    for (int i = 1; i < 10; i++) rd(AW'(i), 1'b0, i == 9);
    m_addr_valid = 1'b0;
    drain();
    check("latency", 64'(sv_rise_cyc - t0), 64'd2);
    check("burst_gapless", 64'(last_pop_cyc - first_pop_cyc), 64'd9);

    // Backpressure: only FD reads fit while s_ready is low.
    s_ready  = 1'b0;
    acc_base = acc;
    fork
      begin
        for (int i = 0; i < 8; i++) rd(AW'(7 - i), i == 0, i == 7);
        m_addr_valid = 1'b0;
      end
      begin
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("credit_accepts", 64'(acc - acc_base), 64'(FD));
        check("full_m_ready", 64'(m_addr_ready), 64'd0);
        @(posedge clk); #1;
        s_ready = 1'b1;
      end
    join
    drain();
    check("bp_all_delivered", 64'(acc - acc_base), 64'd8);

    // Writes interleaved into a read burst.
    fork
      begin
        for (int i = 0; i < 10; i++) rd(AW'(i), i == 0, i == 9);
        m_addr_valid = 1'b0;
      end
      begin
        repeat (2) begin @(posedge clk); #1; end
        for (int k = 0; k < 3; k++) wr(AW'(200 + k), 64'hA0A0_0000 + 64'(k));
      end
    join
    for (int k = 0; k < 3; k++) rd(AW'(200 + k), k == 0, k == 2);
    m_addr_valid = 1'b0;
    drain();

    // Out-of-range reads and the sticky error flag.
    rd(AW'(16384), 1'b1, 1'b1);
    m_addr_valid = 1'b0;
    check("oor_set", 64'(oor_err), 64'd1);
    @(posedge clk); #1;
    check("oor_hold", 64'(oor_err), 64'd1);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check("oor_clear", 64'(oor_err), 64'd0);
    clr_err = 1'b1;
    rd(AW'(16385), 1'b0, 1'b1);
    clr_err = 1'b0;
    m_addr_valid = 1'b0;
    check("oor_set_wins", 64'(oor_err), 64'd1);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    drain();

    // Reset with three beats buffered.
    s_ready = 1'b0;
    for (int i = 5; i < 8; i++) rd(AW'(i), i == 5, 1'b0);
    m_addr_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_s_valid", 64'(s_valid), 64'd1);
    m_addr_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_s_valid", 64'(s_valid), 64'd0);
    check("mid_rst_m_ready", 64'(m_addr_ready), 64'd0);
    m_addr_valid = 1'b0;
    sbq.delete();
    acc = pops;
    @(posedge clk); #1;
    rst_n   = 1'b1;
    s_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_cnt", 64'(dut.r_cnt), 64'd0);
    check("post_rst_m_ready", 64'(m_addr_ready), 64'd1);
    check("post_rst_s_valid", 64'(s_valid), 64'd0);
    rd(AW'(3), 1'b1, 1'b0);
    rd(AW'(4), 1'b0, 1'b1);
    m_addr_valid = 1'b0;
    drain();

    // Random backpressure over 1000 reads.
    for (int i = 0; i < 64; i++) wr(AW'(i), {$urandom, $urandom});
    run_tog = 1;
    fork
      begin
        while (run_tog) begin
          s_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
      begin
        for (int i = 0; i < 1000; i++)
          rd(AW'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        m_addr_valid = 1'b0;
        drain();
        run_tog = 0;
      end
    join
    s_ready = 1'b1;
    check("max_outstanding", 64'(max_out <= int'(FD)), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
